jts16_vtiming: RTL and testbench

JTS16_VTIMING -- requirements
Module: jts16_vtiming

---
 rtl/jts16_vtiming_pkg.sv | 18 +
 rtl/jts16_vtiming_if.sv | 32 +++
 rtl/jts16_vtiming_cnt.sv | 19 +
 rtl/jts16_vtiming.sv | 83 ++++++++
 tb/tb_jts16_vtiming.sv | 132 +++++++++++++
 5 files changed

// File: rtl/jts16_vtiming_pkg.sv
// jts16_vtiming_pkg: S16A/S16B default video timing constants and vint index width helper
package jts16_vtiming_pkg;
  localparam logic [8:0] S16_HCNT_START = 9'h070;
  localparam logic [8:0] S16_HCNT_END   = 9'h1FF;
  localparam logic [8:0] S16_HB_START   = 9'h1FF;
  localparam logic [8:0] S16_HB_END     = 9'h0BF;
  localparam logic [8:0] S16_VCNT_START = 9'h000;
  localparam logic [8:0] S16_VCNT_END   = 9'h104;
  localparam logic [8:0] S16_VB_START   = 9'h0DF;
  localparam logic [8:0] S16_VB_END     = 9'h104;
  localparam logic [8:0] S16_HS_START   = 9'h080;
  localparam logic [8:0] S16_HS_LEN     = 9'd32;
  localparam logic [8:0] S16_VS_START   = 9'h0F0;
  localparam logic [8:0] S16_VS_LEN     = 9'd4;
  function automatic int vidx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jts16_vtiming_if.sv
// jts16_vtiming_if: pixel enable, offset/interrupt controls and the generated timing signals
interface jts16_vtiming_if #(
  parameter int W     = 9,
  parameter int NVINT = 2
);
  localparam int IW = jts16_vtiming_pkg::vidx_w(NVINT);
  logic               pxl_cen;
  logic [3:0]         hoffset;
  logic [NVINT*W-1:0] vint_lines;
  logic [NVINT-1:0]   vint_en;
  logic [W-1:0]       hdump;
  logic [W-1:0]       vdump;
  logic [W-1:0]       vrender;
  logic [W-1:0]       vrender1;
  logic               LHBL;
  logic               LVBL;
  logic               HS;
  logic               VS;
  logic               hstart;
  logic               vstart;
  logic               vint;
  logic [IW-1:0]      vint_idx;
  logic               field;
  modport master (
    input  pxl_cen, hoffset, vint_lines, vint_en,
    output hdump, vdump, vrender, vrender1, LHBL, LVBL, HS, VS, hstart, vstart, vint, vint_idx, field
  );
  modport slave (
    output pxl_cen, hoffset, vint_lines, vint_en,
    input  hdump, vdump, vrender, vrender1, LHBL, LVBL, HS, VS, hstart, vstart, vint, vint_idx, field
  );
endinterface

// File: rtl/jts16_vtiming_cnt.sv
// jts16_vtiming_cnt: wrapping START..STOP counter that exposes its next value and terminal flag
module jts16_vtiming_cnt #(
  parameter int           W     = 9,
  parameter logic [W-1:0] START = '0,
  parameter logic [W-1:0] STOP  = '1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         last
);
  always_comb begin
    last = cnt == STOP;
    nxt  = en ? (last ? START : cnt + 1'b1) : cnt;
  end
  always_ff @(posedge clk) cnt <= rst ? START : nxt;
endmodule

// File: rtl/jts16_vtiming.sv
// jts16_vtiming: System 16 video timing generator with blanking, syncs, frame pulses and line interrupts
module jts16_vtiming
  import jts16_vtiming_pkg::*;
#(
  parameter int           W          = 9,
  parameter logic [W-1:0] HCNT_START = S16_HCNT_START,
  parameter logic [W-1:0] HCNT_END   = S16_HCNT_END,
  parameter logic [W-1:0] HB_START   = S16_HB_START,
  parameter logic [W-1:0] HB_END     = S16_HB_END,
  parameter logic [W-1:0] VCNT_START = S16_VCNT_START,
  parameter logic [W-1:0] VCNT_END   = S16_VCNT_END,
  parameter logic [W-1:0] VB_START   = S16_VB_START,
  parameter logic [W-1:0] VB_END     = S16_VB_END,
  parameter logic [W-1:0] HS_START   = S16_HS_START,
  parameter logic [W-1:0] HS_LEN     = S16_HS_LEN,
  parameter logic [W-1:0] VS_START   = S16_VS_START,
  parameter logic [W-1:0] VS_LEN     = S16_VS_LEN,
  parameter int           NVINT      = 2
)(
  input logic             clk,
  input logic             rst,
  jts16_vtiming_if.master vt
);
  localparam int IW   = vidx_w(NVINT);
  localparam int VLEN = int'(VCNT_END) - int'(VCNT_START) + 1;
  localparam logic [W-1:0] VS_STOP =
    W'(int'(VCNT_START) + (int'(VS_START) - int'(VCNT_START) + int'(VS_LEN)) % VLEN);
  logic [W-1:0]  h_n, v_n, hs_eff;
  logic          h_last, v_last, wrap, hs_n, hs_rise, vmatch;
  logic [3:0]    hoff_l, hoff_n;
  logic [IW-1:0] vsel;
  function automatic logic [W-1:0] vinc(input logic [W-1:0] x);
    return x == VCNT_END ? VCNT_START : x + 1'b1;
  endfunction
  assign wrap = vt.pxl_cen & h_last;
  jts16_vtiming_cnt #(.W(W), .START(HCNT_START), .STOP(HCNT_END)) u_hcnt (
    .clk, .rst, .en(vt.pxl_cen), .cnt(vt.hdump), .nxt(h_n), .last(h_last)
  );
  jts16_vtiming_cnt #(.W(W), .START(VCNT_START), .STOP(VCNT_END)) u_vcnt (
    .clk, .rst, .en(wrap), .cnt(vt.vdump), .nxt(v_n), .last(v_last)
  );
  always_comb begin
    hoff_n  = wrap ? vt.hoffset : hoff_l;
    hs_eff  = HS_START + {{(W-4){hoff_n[3]}}, hoff_n};
    hs_n    = hs_eff >= HCNT_START && hs_eff <= HCNT_END && W'(h_n - hs_eff) < HS_LEN;
    hs_rise = vt.pxl_cen & hs_n & ~vt.HS;
    vmatch  = 1'b0;
    vsel    = '0;
    for (int i = NVINT - 1; i >= 0; i--)
      if (vt.vint_en[i] && vt.vint_lines[i*W +: W] == v_n) begin
        vmatch = 1'b1;
        vsel   = IW'(i);
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      hoff_l      <= '0;
      vt.vrender  <= vinc(VCNT_START);
      vt.vrender1 <= vinc(vinc(VCNT_START));
      vt.LHBL     <= 1'b1;
      vt.LVBL     <= 1'b1;
      vt.HS       <= 1'b0;
      vt.VS       <= 1'b0;
      vt.hstart   <= 1'b0;
      vt.vstart   <= 1'b0;
      vt.vint     <= 1'b0;
      vt.vint_idx <= '0;
      vt.field    <= 1'b0;
    end else begin
      hoff_l      <= hoff_n;
      vt.vrender  <= vinc(v_n);
      vt.vrender1 <= vinc(vinc(v_n));
      vt.hstart   <= wrap;
      vt.vstart   <= wrap & v_last;
      vt.field    <= vt.field ^ (wrap & v_last);
      vt.vint     <= wrap & vmatch;
      if (wrap & vmatch) vt.vint_idx <= vsel;
      if (vt.pxl_cen) vt.LHBL <= h_n == HB_START ? 1'b0 : h_n == HB_END ? 1'b1 : vt.LHBL;
      if (vt.pxl_cen) vt.HS <= hs_n;
      if (wrap) vt.LVBL <= v_n == VB_START ? 1'b0 : v_n == VB_END ? 1'b1 : vt.LVBL;
      if (hs_rise) vt.VS <= v_n == VS_START ? 1'b1 : v_n == VS_STOP ? 1'b0 : vt.VS;
    end
endmodule

// File: tb/tb_jts16_vtiming.sv
// tb_jts16_vtiming: randomized scoreboard check of jts16_vtiming against a frame-position reference model
module tb_jts16_vtiming;
  localparam int HCS = 'h1E0, HCE = 'h1FF, HBS = 'h1FF, HBE = 'h1E6;
  localparam int VCS = 'h000, VCE = 'h013, VBS = 'h010, VBE = 'h013;
  localparam int HSS = 'h1E2, HSL = 12, VSS = 'h011, VSL = 4;
  localparam int HLEN = HCE - HCS + 1, VLEN = VCE - VCS + 1;
  localparam int VS_STOP = VCS + (VSS - VCS + VSL) % VLEN;
  typedef struct packed {
    logic [8:0] h, v, vr, vr1;
    logic lhbl, lvbl, hs, vs, hst, vst, vint, idx, field;
  } snap_t;
  logic clk, rst;
  snap_t q[$];
  int total = 0, bad = 0;
  int mh, mv, mhoff, mlhbl, mlvbl, mhs, mvs, mfield, mhst, mvst, mvint, midx;
  int lines[2];
  bit ven[2];
  jts16_vtiming_if #(.W(9), .NVINT(2)) vt();
  jts16_vtiming #(
    .W(9), .HCNT_START(9'(HCS)), .HCNT_END(9'(HCE)), .HB_START(9'(HBS)), .HB_END(9'(HBE)),
    .VCNT_START(9'(VCS)), .VCNT_END(9'(VCE)), .VB_START(9'(VBS)), .VB_END(9'(VBE)),
    .HS_START(9'(HSS)), .HS_LEN(9'(HSL)), .VS_START(9'(VSS)), .VS_LEN(9'(VSL)), .NVINT(2)
  ) dut (.clk(clk), .rst(rst), .vt(vt));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int vnext(input int v, input int n);
    return VCS + (v - VCS + n) % VLEN;
  endfunction
  task automatic model_step(input bit r, input bit cen);
    bit wrap, hsn;
    int eff;
    if (r) begin
      mh = HCS; mv = VCS; mhoff = 0; mlhbl = 1; mlvbl = 1; mhs = 0; mvs = 0;
      mfield = 0; mhst = 0; mvst = 0; mvint = 0; midx = 0;
    end else begin
      mhst = 0; mvst = 0; mvint = 0;
      if (cen) begin
        wrap = mh == HCE;
        mh = HCS + (mh - HCS + 1) % HLEN;
        if (wrap) begin
          mhoff = int'($signed(vt.hoffset));
          mv = vnext(mv, 1);
          mhst = 1;
          mvst = mv == VCS;
          mfield ^= mvst;
          for (int i = 1; i >= 0; i--)
            if (ven[i] && lines[i] == mv) begin mvint = 1; midx = i; end
          if (mv == VBS) mlvbl = 0; else if (mv == VBE) mlvbl = 1;
        end
        if (mh == HBS) mlhbl = 0; else if (mh == HBE) mlhbl = 1;
        eff = (HSS + mhoff) & 511;
        hsn = eff >= HCS && eff <= HCE && ((mh - eff) & 511) < HSL;
        if (hsn && mhs == 0) begin
          if (mv == VSS) mvs = 1; else if (mv == VS_STOP) mvs = 0;
        end
        mhs = int'(hsn);
      end
    end
  endtask
  task automatic cyc(input bit r, input bit cen);
    snap_t e;
    @(negedge clk);
    rst = r;
    vt.pxl_cen = cen;
    if ($urandom_range(0, 59) == 0) vt.hoffset = 4'($urandom_range(0, 15));
    vt.vint_lines = {9'(lines[1]), 9'(lines[0])};
    vt.vint_en = {ven[1], ven[0]};
    model_step(r, cen);
    e = {9'(mh), 9'(mv), 9'(vnext(mv, 1)), 9'(vnext(mv, 2)), 1'(mlhbl), 1'(mlvbl), 1'(mhs),
         1'(mvs), 1'(mhst), 1'(mvst), 1'(mvint), 1'(midx), 1'(mfield)};
    q.push_back(e);
  endtask
  initial begin
    snap_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {vt.hdump, vt.vdump, vt.vrender, vt.vrender1, vt.LHBL, vt.LVBL, vt.HS, vt.VS,
               vt.hstart, vt.vstart, vt.vint, vt.vint_idx, vt.field};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, e);
        end
      end
    end
  end
  initial begin
    int mode, n;
    rst = 1'b1;
    vt.pxl_cen = 1'b0;
    vt.hoffset = 4'h0;
    lines[0] = 0; lines[1] = 0; ven[0] = 0; ven[1] = 0;
    repeat (3) cyc(1'b1, 1'b0);
    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin lines[1] = 'h10; lines[0] = 'h10; ven[1] = 1; ven[0] = 1; mode = 0; end
        1: begin lines[1] = 'h05; lines[0] = 'h10; ven[1] = 1; ven[0] = 1; mode = 1; end
        2: begin lines[1] = 'h14; lines[0] = 'h10; ven[1] = 1; ven[0] = 1; mode = 2; end
        3: begin lines[1] = 'h00; lines[0] = 'h13; ven[1] = 1; ven[0] = 0; mode = 1; end
        default: begin
          lines[1] = $urandom_range(0, 'h17); lines[0] = $urandom_range(0, 'h17);
          ven[1] = 1'($urandom); ven[0] = 1'($urandom); mode = 3;
        end
      endcase
      if (ph == 1) vt.hoffset = 4'h8;
      if (ph == 2) vt.hoffset = 4'h7;
      n = 0;
      for (int c = 0; c < 3600; c++) begin
        if (ph >= 3 && c == 1777) begin
          cyc(1'b1, 1'b0);
          cyc(1'b1, 1'b0);
          n = 0;
        end
        cyc(1'b0, mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : mode == 2 ? (n % 4 == 0)
                                   : ($urandom_range(0, 2) == 0));
        n++;
      end
    end
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
